// File: rtl/winocnn_pkg.sv
// Shared Winograd result definitions: 6x6 tile of 12-bit signed elements and the queued write entry.
package winocnn_pkg;
  localparam int TILE_N    = 6;
  localparam int RES_W     = 12;
  localparam int TILE_BITS = TILE_N * TILE_N * RES_W;

  // Entry address field is sized for the widest supported ADDR_W; unused high bits are tied to 0.
  localparam int ENTRY_ADDR_W = 32;

  typedef logic [TILE_BITS-1:0] result_tile_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    result_tile_t            tile;
    logic                    accum;
  } result_entry_t;
endpackage

// File: rtl/result_fifo.sv
// Per-PE synchronous result FIFO; a push on a full FIFO lands only when paired with a pop.
module result_fifo
  import winocnn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  result_entry_t din,
  output result_entry_t dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  result_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/pe_result_arbiter.sv
// Serialises PE result tiles onto one SRAM write port: per-PE FIFOs, round-robin grant, registered output.
module pe_result_arbiter
  import winocnn_pkg::*;
#(
  parameter  int NUM_PE     = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int ADDR_W     = 8,
  localparam int SRC_W      = $clog2(NUM_PE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PE-1:0]              res_valid_i,
  input  logic [NUM_PE-1:0][ADDR_W-1:0]  res_addr_i,
  input  logic [NUM_PE-1:0][TILE_BITS-1:0] res_tile_i,
  input  logic                           accum_i,
  input  logic                           err_clr_i,
  output logic                           wr_valid_o,
  input  logic                           wr_ready_i,
  output logic [ADDR_W-1:0]              wr_addr_o,
  output result_tile_t                   wr_data_o,
  output logic                           wr_accum_o,
  output logic [SRC_W-1:0]               wr_src_o,
  output logic [NUM_PE-1:0]              overflow_o,
  output logic                           idle_o
);
  result_entry_t [NUM_PE-1:0] fifo_din, fifo_dout;
  logic [NUM_PE-1:0] fifo_full, fifo_empty, fifo_pop, ovf_set;
  logic [SRC_W-1:0]  last_grant, gnt_idx, cand;
  logic              gnt_found, load, unused_addr_hi;

  always_comb begin
    fifo_din       = '0;
    unused_addr_hi = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      fifo_din[i].addr[ADDR_W-1:0] = res_addr_i[i];
      fifo_din[i].tile             = res_tile_i[i];
      fifo_din[i].accum            = accum_i;
      unused_addr_hi               = unused_addr_hi ^ (^fifo_dout[i].addr);
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_fifo
    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (res_valid_i[g]),
      .pop   (fifo_pop[g]),
      .din   (fifo_din[g]),
      .dout  (fifo_dout[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  assign load = !wr_valid_o || wr_ready_i;

  // First non-empty FIFO after last_grant, wrapping modulo NUM_PE.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_PE; k++) begin
      cand = SRC_W'((int'(last_grant) + k) % NUM_PE);
      if (!gnt_found && !fifo_empty[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    fifo_pop = '0;
    if (load && gnt_found) fifo_pop[gnt_idx] = 1'b1;
  end

  assign ovf_set = res_valid_i & fifo_full & ~fifo_pop;
  assign idle_o  = (&fifo_empty) && !wr_valid_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      wr_accum_o <= 1'b0;
      wr_src_o   <= '0;
      last_grant <= SRC_W'(NUM_PE - 1);
      overflow_o <= '0;
    end else begin
      // A coincident new drop wins over the clear.
      overflow_o <= (overflow_o & ~{NUM_PE{err_clr_i}}) | ovf_set;
      if (load) begin
        wr_valid_o <= gnt_found;
        if (gnt_found) begin
          wr_addr_o  <= fifo_dout[gnt_idx].addr[ADDR_W-1:0];
          wr_data_o  <= fifo_dout[gnt_idx].tile;
          wr_accum_o <= fifo_dout[gnt_idx].accum;
          wr_src_o   <= gnt_idx;
          last_grant <= gnt_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_result_arbiter.sv
// Directed bench for pe_result_arbiter: latency, round-robin order, backpressure, overflow, reset.
module tb_pe_result_arbiter;
  import winocnn_pkg::*;

  localparam int NUM_PE = 4;
  localparam int ADDR_W = 8;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [NUM_PE-1:0]                res_valid_i;
  logic [NUM_PE-1:0][ADDR_W-1:0]    res_addr_i;
  logic [NUM_PE-1:0][TILE_BITS-1:0] res_tile_i;
  logic                             accum_i, err_clr_i, wr_ready_i;
  logic                             wr_valid_o, wr_accum_o, idle_o;
  logic [ADDR_W-1:0]                wr_addr_o;
  result_tile_t                     wr_data_o;
  logic [1:0]                       wr_src_o;
  logic [NUM_PE-1:0]                overflow_o;

  int n_cmp = 0;
  int n_err = 0;

  pe_result_arbiter #(.NUM_PE(NUM_PE), .FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .res_valid_i(res_valid_i), .res_addr_i(res_addr_i),
    .res_tile_i(res_tile_i), .accum_i(accum_i), .err_clr_i(err_clr_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .wr_accum_o(wr_accum_o), .wr_src_o(wr_src_o),
    .overflow_o(overflow_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  // Element e of the tile = base + e (12-bit wrap).
  function automatic result_tile_t tile_pat(input int base);
    result_tile_t t;
    t = '0;
    for (int e = 0; e < TILE_N * TILE_N; e++) t[e*RES_W +: RES_W] = RES_W'(base + e);
    return t;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_push(input int pe, input int addr, input int base);
    res_valid_i[pe] = 1'b1;
    res_addr_i[pe]  = ADDR_W'(addr);
    res_tile_i[pe]  = tile_pat(base);
  endtask

  task automatic test_reset();
    reset = 1'b1; res_valid_i = '0; res_addr_i = '0; res_tile_i = '0;
    accum_i = 1'b0; err_clr_i = 1'b0; wr_ready_i = 1'b0;
    step();
    n_cmp++;
    if (wr_valid_o !== 1'b0 || wr_addr_o !== '0 || wr_data_o !== '0 || wr_src_o !== '0 ||
        wr_accum_o !== 1'b0 || overflow_o !== '0 || idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: valid=%b addr=%h src=%0d accum=%b ovf=%b idle=%b, required 0/0/0/0/0/1",
               wr_valid_o, wr_addr_o, wr_src_o, wr_accum_o, overflow_o, idle_o);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    wr_ready_i = 1'b1;
    accum_i = 1'b1;
    set_push(2, 'h15, 0);
    step();
    res_valid_i = '0; accum_i = 1'b0;
    n_cmp++;
    if (wr_valid_o !== 1'b0 || idle_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_cycle1: valid=%b idle=%b, required valid=0 idle=0", wr_valid_o, idle_o);
    end
    step();
    n_cmp++;
    if (wr_valid_o !== 1'b1 || wr_addr_o !== 8'h15 || wr_src_o !== 2'd2 || wr_accum_o !== 1'b1 ||
        wr_data_o !== tile_pat(0)) begin
      n_err++;
      $display("FAIL single_cycle2: valid=%b addr=%h src=%0d accum=%b data_ok=%b, required 1/15/2/1/1",
               wr_valid_o, wr_addr_o, wr_src_o, wr_accum_o, wr_data_o === tile_pat(0));
    end
    step();
    n_cmp++;
    if (wr_valid_o !== 1'b0 || idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_cycle3: valid=%b idle=%b, required valid=0 idle=1", wr_valid_o, idle_o);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    wr_ready_i = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < NUM_PE; p++) set_push(p, 'h40 + rep*8 + p, 100*rep + 10*p);
      step();
      res_valid_i = '0;
      step();
      for (int k = 0; k < NUM_PE; k++) begin
        n_cmp++;
        if (wr_valid_o !== 1'b1 || wr_src_o !== 2'(k) || wr_addr_o !== 8'('h40 + rep*8 + k) ||
            wr_data_o !== tile_pat(100*rep + 10*k)) begin
          n_err++;
          $display("FAIL rr_order rep%0d slot%0d: valid=%b src=%0d addr=%h, required 1/%0d/%h",
                   rep, k, wr_valid_o, wr_src_o, wr_addr_o, k, 'h40 + rep*8 + k);
        end
        step();
      end
      n_cmp++;
      if (wr_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL rr_drained rep%0d: valid=%b, required 0", rep, wr_valid_o);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    wr_ready_i = 1'b0;
    for (int p = 0; p < 3; p++) set_push(p, 'h50 + p, 200 + p);
    step();
    res_valid_i = '0;
    step();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (wr_valid_o !== 1'b1 || wr_addr_o !== 8'h50 || wr_src_o !== 2'd0 || wr_data_o !== tile_pat(200)) begin
        n_err++;
        $display("FAIL bp_hold c%0d: valid=%b addr=%h src=%0d, required 1/50/0", c, wr_valid_o, wr_addr_o, wr_src_o);
      end
      if (c < 4) step();
    end
    wr_ready_i = 1'b1;
    step();
    for (int k = 1; k < 3; k++) begin
      n_cmp++;
      if (wr_valid_o !== 1'b1 || wr_addr_o !== 8'('h50 + k) || wr_data_o !== tile_pat(200 + k)) begin
        n_err++;
        $display("FAIL bp_drain k%0d: valid=%b addr=%h, required 1/%h", k, wr_valid_o, wr_addr_o, 'h50 + k);
      end
      step();
    end
    n_cmp++;
    if (wr_valid_o !== 1'b0 || idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_end: valid=%b idle=%b, required 0/1", wr_valid_o, idle_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    wr_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_push(1, 'h60 + k, 300 + k);
      step();
    end
    res_valid_i = '0;
    n_cmp++;
    if (overflow_o !== 4'b0010) begin
      n_err++;
      $display("FAIL ovf_set: overflow=%b, required 0010", overflow_o);
    end
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    n_cmp++;
    if (overflow_o !== 4'b0000) begin
      n_err++;
      $display("FAIL ovf_clear: overflow=%b, required 0000", overflow_o);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (wr_valid_o !== 1'b1 || wr_addr_o !== 8'('h60 + k) || wr_src_o !== 2'd1 || wr_data_o !== tile_pat(300 + k)) begin
        n_err++;
        $display("FAIL ovf_write k%0d: valid=%b addr=%h src=%0d, required 1/%h/1", k, wr_valid_o, wr_addr_o, wr_src_o, 'h60 + k);
      end
      wr_ready_i = 1'b1;
      step();
    end
    n_cmp++;
    if (wr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_sixth: valid=%b addr=%h, required valid=0", wr_valid_o, wr_addr_o);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    wr_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_push(0, 'h70 + k, 400 + k);
      step();
    end
    // Output holds tile 0, FIFO holds tiles 1..4: push tile 5 while the FIFO pops.
    n_cmp++;
    if (wr_valid_o !== 1'b1 || wr_addr_o !== 8'h70) begin
      n_err++;
      $display("FAIL fpp_pre: valid=%b addr=%h, required 1/70", wr_valid_o, wr_addr_o);
    end
    set_push(0, 'h75, 405);
    wr_ready_i = 1'b1;
    step();
    res_valid_i = '0;
    n_cmp++;
    if (overflow_o !== 4'b0000) begin
      n_err++;
      $display("FAIL fpp_no_ovf: overflow=%b, required 0000", overflow_o);
    end
    for (int k = 1; k < 6; k++) begin
      n_cmp++;
      if (wr_valid_o !== 1'b1 || wr_addr_o !== 8'('h70 + k) || wr_data_o !== tile_pat(400 + k)) begin
        n_err++;
        $display("FAIL fpp_drain k%0d: valid=%b addr=%h, required 1/%h", k, wr_valid_o, wr_addr_o, 'h70 + k);
      end
      step();
    end
    n_cmp++;
    if (wr_valid_o !== 1'b0 || idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL fpp_end: valid=%b idle=%b, required 0/1", wr_valid_o, idle_o);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    wr_ready_i = 1'b0;
    accum_i = 1'b1;
    set_push(0, 'h80, 500);
    set_push(3, 'h83, 503);
    step();
    res_valid_i = '0; accum_i = 1'b0;
    step();
    n_cmp++;
    if (wr_valid_o !== 1'b1 || wr_addr_o !== 8'h80) begin
      n_err++;
      $display("FAIL midrst_pre: valid=%b addr=%h, required 1/80", wr_valid_o, wr_addr_o);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (wr_valid_o !== 1'b0 || wr_addr_o !== '0 || wr_data_o !== '0 || wr_src_o !== '0 ||
        wr_accum_o !== 1'b0 || idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_async: valid=%b addr=%h src=%0d accum=%b idle=%b, required 0/0/0/0/1",
               wr_valid_o, wr_addr_o, wr_src_o, wr_accum_o, idle_o);
    end
    step();
    reset = 1'b0;
    wr_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (wr_valid_o !== 1'b0 || idle_o !== 1'b1) begin
        n_err++;
        $display("FAIL midrst_quiet c%0d: valid=%b idle=%b, required 0/1", c, wr_valid_o, idle_o);
      end
      step();
    end
    set_push(1, 'h91, 600);
    step();
    res_valid_i = '0;
    step();
    n_cmp++;
    if (wr_valid_o !== 1'b1 || wr_addr_o !== 8'h91 || wr_src_o !== 2'd1 || wr_accum_o !== 1'b0 ||
        wr_data_o !== tile_pat(600)) begin
      n_err++;
      $display("FAIL midrst_new: valid=%b addr=%h src=%0d accum=%b, required 1/91/1/0",
               wr_valid_o, wr_addr_o, wr_src_o, wr_accum_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pe_result_arbiter.md
# pe_result_arbiter

Collects finished Winograd output tiles from `NUM_PE` processing elements and serialises them onto the single output-memory write port. Each PE pushes unconditionally with no backpressure, so every requester has a private FIFO. A round-robin arbiter then drains the FIFOs into a registered valid/ready write stage. The block sits between the PE array result outputs and the output-feature-map SRAM controller.

## Interface
- `NUM_PE`, 4: number of requesting PEs (2..16).
- `FIFO_DEPTH`, 4: entries per requester FIFO; power of two, ≥2.
- `ADDR_W`, 8: result address width.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high; clock `clk`.
- `res_valid_i`  in  NUM_PE  per-PE result valid, one-cycle pulse per tile.
- `res_addr_i`  in  NUM_PE×ADDR_W  per-PE result address.
- `res_tile_i`  in  NUM_PE×432  per-PE 6×6 tile, 12-bit signed elements, element [r][c] at bits [(r*6+c)*12 +: 12].
- `accum_i`  in  1  global mode. 1 means the write accumulates into memory (input-depth pass > 0); 0 means overwrite. Sampled at enqueue and stored per entry.
- `err_clr_i`  in  1  clears the sticky overflow flags.
- `wr_valid_o`  out  1  write request.
- `wr_ready_i`  in  1  memory accepts when `wr_valid_o && wr_ready_i`.
- `wr_addr_o`  out  ADDR_W  write address.
- `wr_data_o`  out  432  tile data.
- `wr_accum_o`  out  1  stored accumulate flag.
- `wr_src_o`  out  clog2(NUM_PE)  index of the granted PE.
- `overflow_o`  out  NUM_PE  sticky per-PE dropped-tile flag.
- `idle_o`  out  1  all FIFOs empty and `wr_valid_o` low.

## Operation
- Enqueue: `res_valid_i[i]` high means {addr, tile, accum_i} is written into FIFO i at the clock edge.
- Full FIFO:
  - A push on a full FIFO is accepted if the same FIFO is popped in the same cycle.
  - Otherwise the tile is dropped and `overflow_o[i]` sets.
  - `overflow_o[i]` stays set until `err_clr_i` or `reset`.
  - If `err_clr_i` and a new overflow coincide, the flag stays set.
- Output stage load condition: load is enabled when `!wr_valid_o || wr_ready_i`.
- Arbitration:
  - When the load condition holds and any FIFO is non-empty, grant the first non-empty FIFO searching from `last_grant+1` upward, modulo `NUM_PE`.
  - Pop the granted FIFO, load its entry into the output register, and set `last_grant`.
  - When the load condition holds and all FIFOs are empty, `wr_valid_o` drops to 0.
- While `wr_valid_o && !wr_ready_i`:
  - The output register and `last_grant` hold.
  - No FIFO pops.
- Output register contents (`wr_addr_o`, `wr_data_o`, `wr_accum_o`, `wr_src_o`) are stable while `wr_valid_o` is high and unaccepted.
- Every enqueued tile is written exactly once. Within one PE, writes keep enqueue order.
- Reset values: `last_grant` = NUM_PE-1 (so PE0 has first priority), all FIFOs empty, all outputs 0, `idle_o` = 1.
- Reset mid-operation: all queued and in-flight tiles are discarded; no partial write is issued.

## Timing
- Latency: `res_valid_i[i]` in cycle 0 → entry visible in FIFO in cycle 1 → `wr_valid_o` in cycle 2 (FIFO empty, output idle). There is no bypass path.
- Throughput: one write per cycle while `wr_ready_i` is held high.
- A FIFO's occupancy does not change when it receives a push and a pop in the same cycle.
- `idle_o` is combinational from FIFO empty flags and `wr_valid_o`.

## Structure
- `winocnn_pkg` holds the shared definitions:
  - `TILE_N` = 6, `RES_W` = 12, `TILE_BITS` = 432.
  - `result_tile_t` (packed 432-bit tile).
  - `result_entry_t` struct {addr, tile, accum}.
- Sub-module `result_fifo`: synchronous FIFO parameterised by depth, with full/empty flags, push/pop, and an async reset. One instance per PE via generate.
- The round-robin grant logic lives in the top module.

## Test plan
- Single tile on PE2 (addr 0x15, tile elements = r*6+c, accum_i = 1), `wr_ready_i` = 1 → in cycle 2: `wr_valid_o` = 1, `wr_addr_o` = 0x15, `wr_src_o` = 2, `wr_accum_o` = 1, data matches; `idle_o` returns to 1 in cycle 3.
- All 4 PEs push in the same cycle, `wr_ready_i` = 1 → four writes on consecutive cycles in order 0, 1, 2, 3. A repeat push → order 0, 1, 2, 3 again, because `last_grant` = 3.
- Backpressure: `wr_ready_i` = 0 for 5 cycles while 3 tiles are queued → `wr_valid_o`, addr, and data are frozen. Release → the remaining tiles drain, none lost or duplicated.
- Overflow: `wr_ready_i` = 0, PE1 pushes 6 tiles (depth 4 plus 1 in the output register) → the 6th tile is dropped and `overflow_o[1]` = 1. `err_clr_i` pulse → 0. Exactly 5 writes appear after release.
- Full-FIFO simultaneous push/pop: PE0 FIFO full, `wr_ready_i` = 1 with grant to PE0, new push same cycle → no overflow, occupancy stays 4.
- Reset asserted while 2 tiles are queued and `wr_valid_o` = 1 → all outputs 0 immediately. After release, no write appears until new pushes arrive.
